dmem_port: RTL and testbench
============================

Name: dmem_port

Overview:
- Load/store front end sitting directly upstream of the byte-write-enable data SRAM.
- Accepts one RV64 memory request per cycle over valid/ready and drives the SRAM port: address, enable, byte write enables, lane-shifted write data.
- Returns a one-cycle-latency response over valid/ready, with load data aligned, masked and sign- or zero-extended.
- Rejects misaligned and out-of-range accesses without touching the SRAM.

Parameters:
- LEN_ADDR, 32, request/SRAM address width.
- DEPTH, 4096, SRAM lines of 64 bits; must match the SRAM instance.
- BASE_ADDR, 32'h8000_0000, byte address of SRAM line 0.

Ports:
- clk  in  1  clock; also drives SRAM clka.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_addr  in  LEN_ADDR  byte address.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 byte, 1 half, 2 word, 3 double.
- req_unsigned  in  1  load zero-extends when 1.
- req_wdata  in  64  store data, right-justified.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumed when resp_valid && resp_ready.
- resp_rdata  out  64  extended load data; 0 for stores and errors.
- resp_err  out  1  access rejected (misaligned or out of range).
- sram_addr  out  LEN_ADDR  to SRAM addra; equals req_addr - BASE_ADDR.
- sram_en  out  1  to SRAM ena.
- sram_din  out  64  to SRAM dina.
- sram_we  out  8  to SRAM wea.
- sram_dout  in  64  from SRAM douta.

Behaviour:
- Reset: resp_valid=0. Held response metadata (offset, size, unsigned, we, err) = 0. Asynchronous on rst_n fall.
- Handshakes:
  - req_ready = !resp_valid || resp_ready. Combinational; no dependency on req_valid.
  - Accept = req_valid && req_ready.
  - req_* must be stable while req_valid && !req_ready.
- Error detection on the request, combinational:
  - mis = (req_addr & ((1<<req_size)-1)) != 0.
  - oor = (req_addr - BASE_ADDR) >= DEPTH*8, computed as an unsigned LEN_ADDR-bit difference. This also rejects addresses below BASE via wrap.
  - err = mis || oor.
- SRAM drive:
  - sram_en = accept && !err.
  - sram_we = req_we ? (((1<<(1<<req_size))-1) << req_addr[2:0]) : 8'h00. Forced to 0 when !sram_en.
  - sram_din = req_wdata << (8*req_addr[2:0]). Upper bits truncated to 64.
- SRAM port timing:
  - The SRAM latches on an enabled edge and commits its write on the following edge.
  - sram_dout is valid the cycle after the enabled edge and stays stable while sram_en=0.
  - The stall strategy relies on this: no new enable is issued while a response is held.
- Response:
  - On accept, resp_valid<=1 and metadata captured.
  - On resp fire with no accept, resp_valid<=0.
  - Latency: response visible exactly 1 cycle after accept. Throughput is 1 request/cycle when resp_ready is held high.
- resp_rdata:
  - Forced to 0 if err or we.
  - Otherwise: sh = sram_dout >> (8*offset), masked to 8/16/32/64 bits by size. If !unsigned, sign-extend from the top bit of that width. size=3 ignores unsigned.
- Simultaneous resp fire and new accept in the same cycle: resp_valid stays 1 and metadata is replaced. This is the back-to-back case.
- Store then load to the same line on consecutive cycles: the load returns the freshly written bytes, because SRAM read data reflects merged new data.
- Erroring request: accepted, no SRAM enable, response next cycle with resp_err=1 and resp_rdata=0. Earlier SRAM contents are unaffected.
- Reset mid-operation:
  - A pending response is dropped.
  - A store already latched by the SRAM still commits (the SRAM has no reset). Verification must tolerate this.
  - No SRAM enable is issued while rst_n=0.

Decomposition:
- Shared package (mem_pkg): mem_size_e enum (MEM_B/H/W/D), function size_bytemask(size, offset) returning 8 bits, function load_extend(data, offset, size, unsigned).
- One natural sub-module: dmem_load_align. Combinational shift/mask/extend of sram_dout using the held metadata.
- Handshake and register logic stay in dmem_port.

Test Plan:
- SD to 0x8000_0008, data 64'h1122_3344_5566_7788, then LD 0x8000_0008 -> resp_rdata=64'h1122_3344_5566_7788, resp_err=0.
- After that SD: LB 0x8000_000F -> 64'h11. LB signed to 0x8000_0008 after SB 0x80 -> 64'hFFFF_FFFF_FFFF_FF80. LBU same -> 64'h80.
- SH 0xBEEF to 0x8000_0012 -> sram_we=8'h0C, sram_din[31:16]=16'hBEEF. Following LW 0x8000_0010 -> 64'hFFFF_FFFF_BEEF_xxxx, with the low half unchanged.
- LW 0x8000_0002 and LD 0x7FFF_FFF8 (wrap) and LD 0x8000_8000 (DEPTH=4096) -> resp_err=1, resp_rdata=0, sram_en never asserted.
- Back-to-back stream of 8 LDs with resp_ready=1 -> one response per cycle, in order. Drop resp_ready for 3 cycles mid-stream -> req_ready=0, sram_en=0, resp_rdata held stable, no request lost or duplicated.
- Pulse rst_n low while resp_valid=1 after SD 0xA5A5 -> resp_valid=0 during and after reset. A later LD of that address returns 0xA5A5.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - access size encoding and byte-lane helpers for the data memory port
package mem_pkg;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2,
    MEM_D = 2'd3
  } mem_size_e;

  // Byte enables for an access of the given size starting at lane 'offset'.
  // Bits shifted past lane 7 fall off; misaligned accesses never reach the SRAM.
  function automatic logic [7:0] size_bytemask(input mem_size_e size, input logic [2:0] offset);
    logic [7:0] m;
    case (size)
      MEM_B:   m = 8'h01;
      MEM_H:   m = 8'h03;
      MEM_W:   m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << offset;
  endfunction

  // True when the low address bits are not a multiple of the access size.
  function automatic logic is_misaligned(input mem_size_e size, input logic [2:0] offset);
    logic m;
    case (size)
      MEM_B:   m = 1'b0;
      MEM_H:   m = offset[0];
      MEM_W:   m = |offset[1:0];
      default: m = |offset;
    endcase
    return m;
  endfunction

  // Right-justify the addressed lanes of a 64-bit line, then zero- or sign-extend.
  // Doubleword loads fill the whole register so the unsigned flag is irrelevant.
  function automatic logic [63:0] load_extend(input logic [63:0] data, input logic [2:0] offset,
                                              input mem_size_e size, input logic is_unsigned);
    logic [63:0] sh;
    logic [63:0] r;
    sh = data >> {offset, 3'b000};
    case (size)
      MEM_B:   r = is_unsigned ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      MEM_H:   r = is_unsigned ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      MEM_W:   r = is_unsigned ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: r = sh;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// rtl/dmem_load_align.sv - lane select, mask and extension of SRAM read data
module dmem_load_align
  import mem_pkg::*;
(
  input  logic [63:0] sram_dout,
  input  logic [2:0]  offset,
  input  mem_size_e   size,
  input  logic        is_unsigned,
  input  logic        zero,
  output logic [63:0] rdata
);

  // Stores and rejected accesses return zero; loads return the aligned, extended value.
  always_comb begin
    rdata = 64'd0;
    if (!zero) begin
      rdata = load_extend(sram_dout, offset, size, is_unsigned);
    end
  end

endmodule

// File: rtl/dmem_port.sv
// rtl/dmem_port.sv - load/store front end driving a byte-write-enable data SRAM
module dmem_port
  import mem_pkg::*;
#(
  parameter int                    LEN_ADDR  = 32,
  parameter int                    DEPTH     = 4096,
  parameter logic [LEN_ADDR-1:0]   BASE_ADDR = 32'h8000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [LEN_ADDR-1:0] req_addr,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [63:0]         req_wdata,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [63:0]         resp_rdata,
  output logic                resp_err,
  output logic [LEN_ADDR-1:0] sram_addr,
  output logic                sram_en,
  output logic [63:0]         sram_din,
  output logic [7:0]          sram_we,
  input  logic [63:0]         sram_dout
);

  // Size of the SRAM window in bytes, one bit wider than the address so it cannot overflow.
  localparam logic [LEN_ADDR:0] SPAN_BYTES = (LEN_ADDR + 1)'(DEPTH * 8);

  logic                resp_valid_q, resp_valid_d;
  logic [2:0]          offset_q,     offset_d;
  mem_size_e           size_q,       size_d;
  logic                unsigned_q,   unsigned_d;
  logic                we_q,         we_d;
  logic                err_q,        err_d;

  logic                accept;
  logic                resp_fire;
  logic [LEN_ADDR-1:0] rel_addr;
  mem_size_e           req_size_e;
  logic                mis;
  logic                oor;
  logic                err;

  // A new request may enter whenever the held response slot is empty or draining.
  always_comb begin
    req_ready  = !resp_valid_q || resp_ready;
    accept     = req_valid && req_ready;
    resp_fire  = resp_valid_q && resp_ready;
  end

  // Address checks; addresses below the base wrap to a huge offset and fail the range test.
  always_comb begin
    req_size_e = mem_size_e'(req_size);
    rel_addr   = req_addr - BASE_ADDR;
    mis        = is_misaligned(req_size_e, req_addr[2:0]);
    oor        = {1'b0, rel_addr} >= SPAN_BYTES;
    err        = mis || oor;
  end

  // SRAM drive; nothing is enabled while reset is asserted or for rejected requests.
  always_comb begin
    sram_addr = rel_addr;
    sram_en   = rst_n && accept && !err;
    sram_din  = req_wdata << {req_addr[2:0], 3'b000};
    sram_we   = 8'h00;
    if (sram_en && req_we) begin
      sram_we = size_bytemask(req_size_e, req_addr[2:0]);
    end
  end

  // Response slot: load on accept (even while draining), clear when drained with no refill.
  always_comb begin
    resp_valid_d = resp_valid_q;
    offset_d     = offset_q;
    size_d       = size_q;
    unsigned_d   = unsigned_q;
    we_d         = we_q;
    err_d        = err_q;
    if (accept) begin
      resp_valid_d = 1'b1;
      offset_d     = req_addr[2:0];
      size_d       = req_size_e;
      unsigned_d   = req_unsigned;
      we_d         = req_we;
      err_d        = err;
    end else if (resp_fire) begin
      resp_valid_d = 1'b0;
    end
  end

  // Response slot registers; a pending response is dropped by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      offset_q     <= 3'd0;
      size_q       <= MEM_B;
      unsigned_q   <= 1'b0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      offset_q     <= offset_d;
      size_q       <= size_d;
      unsigned_q   <= unsigned_d;
      we_q         <= we_d;
      err_q        <= err_d;
    end
  end

  dmem_load_align u_load_align (
    .sram_dout   (sram_dout),
    .offset      (offset_q),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .zero        (err_q || we_q),
    .rdata       (resp_rdata)
  );

  // Response outputs straight from the held slot.
  always_comb begin
    resp_valid = resp_valid_q;
    resp_err   = err_q;
  end

endmodule

// File: tb/tb_dmem_port.sv
// tb/tb_dmem_port.sv - directed self-checking bench for dmem_port with a behavioural SRAM
module tb_dmem_port;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [31:0] sram_addr;
  logic        sram_en;
  logic [63:0] sram_din;
  logic [7:0]  sram_we;
  logic [63:0] sram_dout;

  int n_cmp = 0;
  int n_bad = 0;

  logic        obs_en;
  logic [7:0]  obs_we;
  logic [63:0] obs_din;
  logic [31:0] obs_addr;
  logic        obs_rv;
  logic [63:0] obs_rd;
  logic        obs_err;

  dmem_port dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .sram_addr    (sram_addr),
    .sram_en      (sram_en),
    .sram_din     (sram_din),
    .sram_we      (sram_we),
    .sram_dout    (sram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural byte-write SRAM: read data on an enabled edge reflects merged write data.
  logic [63:0] mem [0:4095];
  logic [63:0] sram_merged;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 64'd0;
    sram_dout = 64'd0;
  end

  always_comb begin
    sram_merged = mem[sram_addr[14:3]];
    for (int b = 0; b < 8; b++) begin
      if (sram_we[b]) sram_merged[8*b +: 8] = sram_din[8*b +: 8];
    end
  end

  always @(posedge clk) begin
    if (sram_en) begin
      mem[sram_addr[14:3]] <= sram_merged;
      sram_dout            <= sram_merged;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; drives one request, samples the SRAM side at the falling
  // edge, and returns at the next posedge+1 with the response sampled.
  task automatic do_req(input logic [31:0] addr, input logic we, input logic [1:0] size,
                        input logic uns, input logic [63:0] wdata);
    req_valid    = 1'b1;
    req_addr     = addr;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wdata;
    resp_ready   = 1'b1;
    #4;
    obs_en   = sram_en;
    obs_we   = sram_we;
    obs_din  = sram_din;
    obs_addr = sram_addr;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    obs_rv  = resp_valid;
    obs_rd  = resp_rdata;
    obs_err = resp_err;
  endtask

  localparam logic [31:0] STREAM_BASE = 32'h8000_0100;
  logic [63:0] stream_exp [0:7];
  int issued;
  int recv;
  int cyc;

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b1;
    req_addr     = 32'h8000_0000;
    req_we       = 1'b1;
    req_size     = 2'd3;
    req_unsigned = 1'b0;
    req_wdata    = 64'hDEAD_BEEF_DEAD_BEEF;
    resp_ready   = 1'b1;

    #3;
    check_eq("reset_resp_valid", {63'd0, resp_valid}, 64'd0);
    check_eq("reset_sram_en", {63'd0, sram_en}, 64'd0);
    check_eq("reset_req_ready", {63'd0, req_ready}, 64'd1);
    repeat (2) @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst_n     = 1'b1;

    // SD then LD of the same line
    do_req(32'h8000_0008, 1'b1, 2'd3, 1'b0, 64'h1122_3344_5566_7788);
    check_eq("sd_en", {63'd0, obs_en}, 64'd1);
    check_eq("sd_we", {56'd0, obs_we}, 64'hFF);
    check_eq("sd_addr", {32'd0, obs_addr}, 64'h8);
    check_eq("sd_resp_valid", {63'd0, obs_rv}, 64'd1);
    check_eq("sd_rdata", obs_rd, 64'd0);
    do_req(32'h8000_0008, 1'b0, 2'd3, 1'b0, 64'd0);
    check_eq("ld_rdata", obs_rd, 64'h1122_3344_5566_7788);
    check_eq("ld_err", {63'd0, obs_err}, 64'd0);

    do_req(32'h8000_000F, 1'b0, 2'd0, 1'b0, 64'd0);
    check_eq("lb_0f", obs_rd, 64'h11);

    do_req(32'h8000_0008, 1'b1, 2'd0, 1'b0, 64'h80);
    check_eq("sb_we", {56'd0, obs_we}, 64'h01);
    do_req(32'h8000_0008, 1'b0, 2'd0, 1'b0, 64'd0);
    check_eq("lb_signed", obs_rd, 64'hFFFF_FFFF_FFFF_FF80);
    do_req(32'h8000_0008, 1'b0, 2'd0, 1'b1, 64'd0);
    check_eq("lbu", obs_rd, 64'h80);

    // Halfword store into lanes 2..3, then word load of the low half of the line
    do_req(32'h8000_0012, 1'b1, 2'd1, 1'b0, 64'hBEEF);
    check_eq("sh_we", {56'd0, obs_we}, 64'h0C);
    check_eq("sh_din", {48'd0, obs_din[31:16]}, 64'hBEEF);
    do_req(32'h8000_0010, 1'b0, 2'd2, 1'b0, 64'd0);
    check_eq("lw_after_sh", obs_rd, 64'hFFFF_FFFF_BEEF_0000);
    do_req(32'h8000_0012, 1'b0, 2'd1, 1'b1, 64'd0);
    check_eq("lhu_after_sh", obs_rd, 64'hBEEF);

    // Rejected accesses
    do_req(32'h8000_0002, 1'b0, 2'd2, 1'b0, 64'd0);
    check_eq("mis_lw_en", {63'd0, obs_en}, 64'd0);
    check_eq("mis_lw_err", {63'd0, obs_err}, 64'd1);
    check_eq("mis_lw_rdata", obs_rd, 64'd0);
    do_req(32'h7FFF_FFF8, 1'b0, 2'd3, 1'b0, 64'd0);
    check_eq("wrap_en", {63'd0, obs_en}, 64'd0);
    check_eq("wrap_err", {63'd0, obs_err}, 64'd1);
    check_eq("wrap_rdata", obs_rd, 64'd0);
    do_req(32'h8000_8000, 1'b0, 2'd3, 1'b0, 64'd0);
    check_eq("oor_en", {63'd0, obs_en}, 64'd0);
    check_eq("oor_err", {63'd0, obs_err}, 64'd1);
    do_req(32'h8000_7FF8, 1'b0, 2'd3, 1'b0, 64'd0);
    check_eq("last_line_en", {63'd0, obs_en}, 64'd1);
    check_eq("last_line_err", {63'd0, obs_err}, 64'd0);
    do_req(32'h8000_000C, 1'b1, 2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    check_eq("mis_sd_we", {56'd0, obs_we}, 64'h00);
    check_eq("mis_sd_err", {63'd0, obs_err}, 64'd1);
    do_req(32'h8000_0008, 1'b0, 2'd3, 1'b0, 64'd0);
    check_eq("line_untouched", obs_rd, 64'h1122_3344_5566_7780);

    // Back-to-back stream with a three-cycle response stall in the middle
    for (int i = 0; i < 8; i++) begin
      stream_exp[i] = {32'hC0DE_0000 + 32'(i), 32'h0000_1000 + 32'(i)};
      do_req(STREAM_BASE + 32'(8 * i), 1'b1, 2'd3, 1'b0, stream_exp[i]);
    end
    @(posedge clk);
    #1;
    issued = 0;
    recv   = 0;
    cyc    = 0;
    req_we = 1'b0;
    req_size = 2'd3;
    while (recv < 8 && cyc < 40) begin
      resp_ready = !(cyc >= 4 && cyc <= 6);
      req_valid  = (issued < 8);
      req_addr   = STREAM_BASE + 32'(8 * issued);
      #4;
      if (cyc >= 4 && cyc <= 6) begin
        check_eq("stall_req_ready", {63'd0, req_ready}, 64'd0);
        check_eq("stall_sram_en", {63'd0, sram_en}, 64'd0);
        check_eq("stall_resp_valid", {63'd0, resp_valid}, 64'd1);
        check_eq("stall_rdata_held", resp_rdata, stream_exp[recv]);
      end
      if (resp_valid && resp_ready) begin
        check_eq("stream_rdata", resp_rdata, stream_exp[recv]);
        recv++;
      end
      if (req_valid && req_ready) issued++;
      @(posedge clk);
      #1;
      cyc++;
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    check_eq("stream_recv", 64'(recv), 64'd8);
    check_eq("stream_issued", 64'(issued), 64'd8);
    check_eq("stream_cycles", 64'(cyc), 64'd12);

    // Reset while a store response is held
    do_req(32'h8000_0200, 1'b1, 2'd3, 1'b0, 64'hA5A5);
    check_eq("pre_reset_valid", {63'd0, obs_rv}, 64'd1);
    resp_ready = 1'b0;
    rst_n      = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 32'h8000_0200;
    #1;
    check_eq("in_reset_valid", {63'd0, resp_valid}, 64'd0);
    check_eq("in_reset_sram_en", {63'd0, sram_en}, 64'd0);
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_reset_valid", {63'd0, resp_valid}, 64'd0);
    do_req(32'h8000_0200, 1'b0, 2'd3, 1'b0, 64'd0);
    check_eq("post_reset_ld", obs_rd, 64'hA5A5);
    check_eq("post_reset_err", {63'd0, obs_err}, 64'd0);

    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
